alu181_vector_player: RTL
=========================

// Module: alu181_vector_player
// PURPOSE
//  Synthesizable stimulus/response end of the 74181 test scaffold. Steps through a vector ROM,
//  drives the ALU select/data/carry pins and waits a settle interval. It then samples the ALU
//  result pins and compares them with expected values under a per-bit care mask.
//  It reports pass/fail, a saturating failure count and the first failing vector index.
//  Sits opposite the 74181 DUT in the scaffold; replaces the generated tb on FPGA/hardware-in-loop runs.
// PARAMETERS
//  NUM_VECTORS    16  number of vectors in ROM (>=1)
//  SETTLE_CYCLES  2   cycles between driving inputs and sampling outputs (>=1)
//  FAIL_W         8   width of fail_count; saturates at 2**FAIL_W-1
//  ADDR_W         $clog2(NUM_VECTORS) (min 1), derived, not overridden
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high
//  start       in   1       pulse; begins a run from vector 0 when idle/done
//  cn          out  1       to DUT Cn
//  a_n         out  4       to DUT ~A3..~A0
//  b_n         out  4       to DUT ~B3..~B0
//  s           out  4       to DUT S3..S0
//  m           out  1       to DUT M
//  f_n         in   4       from DUT ~F3..~F0
//  g_n, p_n    in   1 each  from DUT ~G, ~P
//  aeqb        in   1       from DUT A=B
//  cn4         in   1       from DUT Cn+4
//  busy        out  1       high from cycle after accepted start until DONE
//  done        out  1       high in DONE; cleared by next accepted start
//  pass        out  1       valid when done: fail_count==0
//  fail_count  out  FAIL_W  mismatching vectors this run, saturating
//  first_fail  out  ADDR_W  index of first mismatching vector; valid when fail_count!=0
// BEHAVIOUR
//  Reset, all outputs: cn=0 a_n=0 b_n=0 s=0 m=0 busy=0 done=0 pass=0 fail_count=0 first_fail=0; state IDLE.
//  Vector word, 30b: {care[7:0], exp[7:0], cn, a_n[3:0], b_n[3:0], s[3:0], m}.
//  exp/care bit order: {cn4, aeqb, p_n, g_n, f_n[3:0]}.
//  FSM:
//   IDLE  : start -> FETCH, idx=0, fail_count=0, done=0, busy=1.
//   FETCH : ROM registered read at idx; 1-cycle latency -> DRIVE.
//   DRIVE : register the 14 drive bits onto output ports; load settle counter -> SETTLE.
//   SETTLE: count SETTLE_CYCLES -> CHECK.
//   CHECK : mism = |((obs ^ exp) & care).
//           If mism: fail_count++ (saturating); if fail_count was 0, first_fail=idx.
//           idx==NUM_VECTORS-1 -> DONE, else idx++ -> FETCH.
//   DONE  : busy=0, done=1, pass=(fail_count==0). start -> FETCH as from IDLE.
//  Per-vector latency = SETTLE_CYCLES+3 cycles.
//  done asserts exactly NUM_VECTORS*(SETTLE_CYCLES+3)+1 cycles after the start cycle.
//  Drive pins hold the last applied vector in DONE and only change in DRIVE.
//  start while busy is ignored; no restart and no counter change.
//  rst mid-run overrides everything: next cycle matches reset values exactly.
//  care bit 0 = don't care (e.g. open-collector A=B unresolved); care==0 never fails.
//  Obs inputs are sampled only in CHECK; glitches in other states have no effect.
//  fail_count at 2**FAIL_W-1 stays there; first_fail is unaffected.
// STRUCTURE
//  Shared package alu181_pkg: VEC_W=30, drive/exp/care field offsets, state enum
//   {IDLE,FETCH,DRIVE,SETTLE,CHECK,DONE}.
//  Sub-module alu181_vector_rom (clk, addr -> registered 30b data, $readmemh init file).
//  Top holds the FSM, counters, compare and output registers.
// TESTING
//  1 Behavioural 74181 model, 16 golden vectors, SETTLE=2.
//    start -> done at cycle 81, pass=1, fail_count=0, busy low same cycle.
//  2 Model f_n[0] stuck-at-1; vectors 3,7,9 expect f_n[0]=0.
//    -> fail_count=3, first_fail=3, pass=0.
//  3 Vector 5 has care[aeqb]=0 and aeqb forced opposite exp -> no failure counted, pass=1.
//  4 Assert rst at cycle 20 of a run -> next cycle all outputs zero, IDLE.
//    Fresh start then completes normally.
//  5 Pulse start at cycles 10 and 40 of a run -> ignored; done still at cycle 81, vectors 0..15 once.
//  6 FAIL_W=2, all 16 vectors failing -> fail_count=3 (saturated), first_fail=0.

Source files
------------

// File: rtl/alu181_pkg.sv
// Shared types and field layout for the 74181 vector player and its ROM.
package alu181_pkg;

  localparam int unsigned VEC_W = 30;
  localparam int unsigned DRV_W = 14;
  localparam int unsigned OBS_W = 8;

  localparam int unsigned DRV_LSB  = 0;
  localparam int unsigned EXP_LSB  = 14;
  localparam int unsigned CARE_LSB = 22;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Observation bit order in exp/care: {cn4, aeqb, p_n, g_n, f_n[3:0]}
  typedef struct packed {
    logic [OBS_W-1:0] care;
    logic [OBS_W-1:0] exp_bits;
    logic             cn;
    logic [3:0]       a_n;
    logic [3:0]       b_n;
    logic [3:0]       s;
    logic             m;
  } vec_t;

  function automatic logic mismatch(input logic [OBS_W-1:0] obs,
                                    input logic [OBS_W-1:0] exp_bits,
                                    input logic [OBS_W-1:0] care);
    return |((obs ^ exp_bits) & care);
  endfunction

endpackage

// File: rtl/alu181_vector_rom.sv
// Vector ROM with a one-cycle registered read; contents fixed at elaboration.
module alu181_vector_rom
  import alu181_pkg::*;
#(
  parameter int unsigned                   NUM_VECTORS = 16,
  parameter int unsigned                   ADDR_W      = 4,
  parameter logic [NUM_VECTORS*VEC_W-1:0]  INIT        = '0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output vec_t              data
);

  always_ff @(posedge clk) begin
    data <= vec_t'(INIT[32'(addr) * VEC_W +: VEC_W]);
  end

endmodule

// File: rtl/alu181_vector_player.sv
// Steps through the vector ROM, drives the 74181 pins, waits to settle and
// compares the sampled result pins against expected values under a care mask.
module alu181_vector_player
  import alu181_pkg::*;
#(
  parameter int unsigned                  NUM_VECTORS   = 16,
  parameter int unsigned                  SETTLE_CYCLES = 2,
  parameter int unsigned                  FAIL_W        = 8,
  parameter logic [NUM_VECTORS*VEC_W-1:0] ROM_INIT      = '0,
  localparam int unsigned                 ADDR_W        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cn,
  output logic [3:0]        a_n,
  output logic [3:0]        b_n,
  output logic [3:0]        s,
  output logic              m,
  input  logic [3:0]        f_n,
  input  logic              g_n,
  input  logic              p_n,
  input  logic              aeqb,
  input  logic              cn4,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_count,
  output logic [ADDR_W-1:0] first_fail
);

  localparam int unsigned       SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_VECTORS - 1);
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [SET_W-1:0]   settle_cnt;
  vec_t               rom_q;
  logic [OBS_W-1:0]   obs_c;
  logic               mism_c;

  alu181_vector_rom #(
    .NUM_VECTORS (NUM_VECTORS),
    .ADDR_W      (ADDR_W),
    .INIT        (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (idx),
    .data (rom_q)
  );

  assign obs_c  = {cn4, aeqb, p_n, g_n, f_n};
  assign mism_c = mismatch(obs_c, rom_q.exp_bits, rom_q.care);

  // Sequencer: ROM address is held at idx from FETCH through CHECK, so rom_q stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      cn         <= 1'b0;
      a_n        <= '0;
      b_n        <= '0;
      s          <= '0;
      m          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            fail_count <= '0;
            first_fail <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= DRIVE;
        DRIVE: begin
          cn         <= rom_q.cn;
          a_n        <= rom_q.a_n;
          b_n        <= rom_q.b_n;
          s          <= rom_q.s;
          m          <= rom_q.m;
          settle_cnt <= SETTLE_LOAD;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - SET_W'(1);
        end
        CHECK: begin
          if (mism_c) begin
            if (fail_count != '1) fail_count <= fail_count + FAIL_W'(1);
            if (fail_count == '0) first_fail <= idx;
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_count == '0) && !mism_c;
            state <= DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
